// File: rtl/iq_demod_accum.sv
// iq_demod_accum: mixes signed ADC samples against the DDS sin/cos reference
// and integrates each product over a programmed sample count. The result
// leaves as one I/Q pair with a single-cycle valid pulse. Accumulators saturate
// instead of wrapping, and a sticky ovf flag records any saturation in the run.
module iq_demod_accum #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         n_samples,
    input  logic signed [DATA_W-1:0] adc_data,
    input  logic                     adc_val,
    input  logic signed [DATA_W-1:0] sin_ref,
    input  logic signed [DATA_W-1:0] cos_ref,
    input  logic                     ref_val,
    output logic signed [ACC_W-1:0]  i_out,
    output logic signed [ACC_W-1:0]  q_out,
    output logic                     out_val,
    output logic                     busy,
    output logic                     ovf
);

    localparam int PW = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic             start_ok;
    logic             accept;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             flush_cnt;
    logic             dump_pend;

    logic signed [DATA_W-1:0] adc_p0, sin_p0, cos_p0;
    logic                     vld_p0;
    logic signed [PW-1:0]     prod_i_p1, prod_q_p1;
    logic                     vld_p1;
    logic signed [ACC_W-1:0]  acc_i_p2, acc_q_p2;

    logic signed [ACC_W-1:0]  ext_i, ext_q;
    logic signed [ACC_W:0]    sum_i, sum_q;

    // One guard bit above the accumulator width: overflow shows as the top two
    // bits disagreeing.
    function automatic logic sat_hit(input logic signed [ACC_W:0] s);
        return s[ACC_W] != s[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_clip(input logic signed [ACC_W:0] s);
        logic signed [ACC_W-1:0] r;
        if (!sat_hit(s)) begin
            r = s[ACC_W-1:0];
        end else if (s[ACC_W]) begin
            r = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            r = {1'b0, {(ACC_W-1){1'b1}}};
        end
        return r;
    endfunction

    // Next-state decode; also flags accepted starts and accepted sample pairs.
    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        accept    = 1'b0;
        cnt_inc   = cnt + 1'b1;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = (n_samples == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (adc_val && ref_val) begin
                    accept = 1'b1;
                    if (cnt_inc == n_lat) begin
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, sample counter, flush timer and the pending-dump flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n_lat     <= '0;
            cnt       <= '0;
            flush_cnt <= 1'b0;
            dump_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= (state == FLUSH) && !flush_cnt;
            // A zero-length start issued from DONE re-enters DONE and still dumps.
            dump_pend <= (state_nxt == DONE) && ((state != DONE) || start_ok);
            if (start_ok) begin
                n_lat <= n_samples;
                cnt   <= '0;
            end else if (accept) begin
                cnt <= cnt_inc;
            end
        end
    end

    assign busy = (state == ACCUM) || (state == FLUSH);

    // ---- stage p0: capture the accepted sample and reference pair ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            adc_p0 <= '0;
            sin_p0 <= '0;
            cos_p0 <= '0;
        end else begin
            vld_p0 <= accept;
            if (accept) begin
                adc_p0 <= adc_data;
                sin_p0 <= sin_ref;
                cos_p0 <= cos_ref;
            end
        end
    end

    // ---- stage p1: full-precision products ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            prod_i_p1 <= '0;
            prod_q_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                prod_i_p1 <= PW'(adc_p0) * PW'(cos_p0);
                prod_q_p1 <= PW'(adc_p0) * PW'(sin_p0);
            end
        end
    end

    // Sign-extend the products and form the guarded sums for the accumulators.
    always_comb begin
        ext_i = ACC_W'(prod_i_p1);
        ext_q = ACC_W'(prod_q_p1);
        sum_i = {acc_i_p2[ACC_W-1], acc_i_p2} + {ext_i[ACC_W-1], ext_i};
        sum_q = {acc_q_p2[ACC_W-1], acc_q_p2} + {ext_q[ACC_W-1], ext_q};
    end

    // ---- stage p2: saturating accumulate; bubbles leave the sums untouched ----
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_i_p2 <= '0;
            acc_q_p2 <= '0;
            ovf      <= 1'b0;
        end else if (start_ok) begin
            acc_i_p2 <= '0;
            acc_q_p2 <= '0;
            ovf      <= 1'b0;
        end else if (vld_p1) begin
            acc_i_p2 <= sat_clip(sum_i);
            acc_q_p2 <= sat_clip(sum_q);
            if (sat_hit(sum_i) || sat_hit(sum_q)) begin
                ovf <= 1'b1;
            end
        end
    end

    // ---- output register: load once on entry to DONE, then hold ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_val <= 1'b0;
            i_out   <= '0;
            q_out   <= '0;
        end else begin
            out_val <= dump_pend;
            if (dump_pend) begin
                i_out <= acc_i_p2;
                q_out <= acc_q_p2;
            end
        end
    end

endmodule

// File: tb/tb_iq_demod_accum.sv
// Directed bench for iq_demod_accum: a default-width instance (a) and an
// ACC_W=32 instance (b) share one stimulus stream.
module tb_iq_demod_accum;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [15:0]        n_samples = '0;
    logic signed [15:0] adc_data = '0;
    logic               adc_val = 1'b0;
    logic signed [15:0] sin_ref = '0;
    logic signed [15:0] cos_ref = '0;
    logic               ref_val = 1'b0;

    logic signed [39:0] i_a, q_a;
    logic               val_a, busy_a, ovf_a;
    logic signed [31:0] i_b, q_b;
    logic               val_b, busy_b, ovf_b;

    int ntotal = 0;
    int npass  = 0;
    int npulse_a = 0;

    iq_demod_accum dut_a (
        .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
        .adc_data(adc_data), .adc_val(adc_val), .sin_ref(sin_ref),
        .cos_ref(cos_ref), .ref_val(ref_val), .i_out(i_a), .q_out(q_a),
        .out_val(val_a), .busy(busy_a), .ovf(ovf_a)
    );

    iq_demod_accum #(.ACC_W(32)) dut_b (
        .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
        .adc_data(adc_data), .adc_val(adc_val), .sin_ref(sin_ref),
        .cos_ref(cos_ref), .ref_val(ref_val), .i_out(i_b), .q_out(q_b),
        .out_val(val_b), .busy(busy_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (val_a) npulse_a++;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        n_samples = 16'(n);
        step();
        start     = 1'b0;
    endtask

    // Steps until out_val of instance a shows; k = edges waited, -1 on timeout.
    task automatic wait_val(input int max, output int k);
        k = -1;
        for (int c = 1; c <= max; c++) begin
            step();
            if (val_a) begin
                k = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        ntotal++; if ({i_a, q_a} !== 80'd0) $display("FAIL reset_out_a: got %0d/%0d want 0/0", i_a, q_a); else npass++;
        ntotal++; if ({val_a, busy_a, ovf_a} !== 3'b000) $display("FAIL reset_ctl_a: got %b want 000", {val_a, busy_a, ovf_a}); else npass++;
        ntotal++; if ({i_b, q_b, val_b, busy_b, ovf_b} !== 67'd0) $display("FAIL reset_b: got %0d/%0d %b want 0", i_b, q_b, {val_b, busy_b, ovf_b}); else npass++;
    endtask

    task automatic test_basic();
        int k;
        int p0;
        adc_data = 16'sd1000; cos_ref = 16'sd16384; sin_ref = 16'sd0;
        adc_val = 1'b1; ref_val = 1'b1;
        p0 = npulse_a;
        do_start(4);
        ntotal++; if (busy_a !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy_a); else npass++;
        wait_val(20, k);
        ntotal++; if (k !== 7) $display("FAIL basic_latency: got %0d want 7", k); else npass++;
        ntotal++; if (i_a !== 40'sd65536000) $display("FAIL basic_i: got %0d want 65536000", i_a); else npass++;
        ntotal++; if (q_a !== 40'sd0) $display("FAIL basic_q: got %0d want 0", q_a); else npass++;
        ntotal++; if (ovf_a !== 1'b0) $display("FAIL basic_ovf: got %b want 0", ovf_a); else npass++;
        step(); step();
        ntotal++; if (npulse_a !== p0 + 1) $display("FAIL basic_pulses: got %0d want %0d", npulse_a - p0, 1); else npass++;
        ntotal++; if (busy_a !== 1'b0) $display("FAIL basic_idle_busy: got %b want 0", busy_a); else npass++;
    endtask

    task automatic test_gaps();
        int k;
        int p0;
        adc_val = 1'b0; ref_val = 1'b0;
        adc_data = -16'sd2000; sin_ref = -16'sd32768; cos_ref = 16'sd0;
        p0 = npulse_a;
        k = -1;
        do_start(3);
        for (int c = 1; c <= 40; c++) begin
            if (c % 2 == 1) begin
                adc_data = -16'sd2000; adc_val = 1'b1; ref_val = 1'b1;
            end else begin
                adc_data = 16'sd5000; adc_val = (c % 4 == 0); ref_val = (c % 4 != 0);
            end
            step();
            if (val_a && k < 0) k = c;
        end
        adc_val = 1'b0; ref_val = 1'b0;
        ntotal++; if (k !== 8) $display("FAIL gaps_latency: got %0d want 8", k); else npass++;
        ntotal++; if (q_a !== 40'sd196608000) $display("FAIL gaps_q: got %0d want 196608000", q_a); else npass++;
        ntotal++; if (i_a !== 40'sd0) $display("FAIL gaps_i: got %0d want 0", i_a); else npass++;
        ntotal++; if (npulse_a !== p0 + 1) $display("FAIL gaps_pulses: got %0d want 1", npulse_a - p0); else npass++;
    endtask

    task automatic test_start_busy();
        int k;
        int p0;
        adc_data = 16'sd3; cos_ref = 16'sd7; sin_ref = -16'sd2;
        adc_val = 1'b1; ref_val = 1'b1;
        p0 = npulse_a;
        do_start(5);
        step(); step();
        start = 1'b1; n_samples = 16'd1;
        step();
        start = 1'b0; n_samples = 16'd0;
        wait_val(20, k);
        ntotal++; if (k !== 5) $display("FAIL busy_start_latency: got %0d want 5", k); else npass++;
        ntotal++; if (i_a !== 40'sd105) $display("FAIL busy_start_i: got %0d want 105", i_a); else npass++;
        ntotal++; if (q_a !== -40'sd30) $display("FAIL busy_start_q: got %0d want -30", q_a); else npass++;
        for (int c = 0; c < 10; c++) step();
        ntotal++; if (npulse_a !== p0 + 1) $display("FAIL busy_start_pulses: got %0d want 1", npulse_a - p0); else npass++;
    endtask

    task automatic test_abort();
        int k;
        int p0;
        adc_data = 16'sd1; cos_ref = 16'sd1; sin_ref = 16'sd0;
        adc_val = 1'b1; ref_val = 1'b1;
        do_start(10);
        for (int c = 0; c < 4; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ntotal++; if ({i_a, q_a} !== 80'd0) $display("FAIL abort_out: got %0d/%0d want 0/0", i_a, q_a); else npass++;
        ntotal++; if ({val_a, busy_a, ovf_a} !== 3'b000) $display("FAIL abort_ctl: got %b want 000", {val_a, busy_a, ovf_a}); else npass++;
        p0 = npulse_a;
        for (int c = 0; c < 20; c++) step();
        ntotal++; if (npulse_a !== p0) $display("FAIL abort_no_val: got %0d pulses want 0", npulse_a - p0); else npass++;
        do_start(2);
        wait_val(20, k);
        ntotal++; if (k !== 5) $display("FAIL abort_rerun_latency: got %0d want 5", k); else npass++;
        ntotal++; if (i_a !== 40'sd2) $display("FAIL abort_rerun_i: got %0d want 2", i_a); else npass++;
    endtask

    task automatic test_sat();
        int k;
        adc_data = -16'sd32768; cos_ref = -16'sd32768; sin_ref = 16'sd32767;
        adc_val = 1'b1; ref_val = 1'b1;
        do_start(2);
        wait_val(20, k);
        ntotal++; if (k !== 5) $display("FAIL sat_latency: got %0d want 5", k); else npass++;
        ntotal++; if (i_b !== 32'sd2147483647) $display("FAIL sat_pos_i: got %0d want 2147483647", i_b); else npass++;
        ntotal++; if (ovf_b !== 1'b1) $display("FAIL sat_pos_ovf: got %b want 1", ovf_b); else npass++;
        ntotal++; if (q_b !== -32'sd2147418112) $display("FAIL sat_pos_q: got %0d want -2147418112", q_b); else npass++;
        ntotal++; if (i_a !== 40'sd2147483648) $display("FAIL sat_wide_i: got %0d want 2147483648", i_a); else npass++;
        ntotal++; if (ovf_a !== 1'b0) $display("FAIL sat_wide_ovf: got %b want 0", ovf_a); else npass++;
        cos_ref = 16'sd0;
        do_start(3);
        ntotal++; if (ovf_b !== 1'b0) $display("FAIL sat_ovf_clear: got %b want 0", ovf_b); else npass++;
        wait_val(20, k);
        ntotal++; if (q_b !== -32'sd2147483648) $display("FAIL sat_neg_q: got %0d want -2147483648", q_b); else npass++;
        ntotal++; if (i_b !== 32'sd0) $display("FAIL sat_neg_i: got %0d want 0", i_b); else npass++;
        ntotal++; if (ovf_b !== 1'b1) $display("FAIL sat_neg_ovf: got %b want 1", ovf_b); else npass++;
        ntotal++; if (q_a !== -40'sd3221127168) $display("FAIL sat_neg_wide_q: got %0d want -3221127168", q_a); else npass++;
    endtask

    task automatic test_zero();
        adc_data = 16'sd7; cos_ref = 16'sd7; sin_ref = 16'sd7;
        adc_val = 1'b1; ref_val = 1'b1;
        do_start(0);
        ntotal++; if (busy_a !== 1'b0) $display("FAIL zero_busy0: got %b want 0", busy_a); else npass++;
        ntotal++; if (ovf_b !== 1'b0) $display("FAIL zero_ovf_clear: got %b want 0", ovf_b); else npass++;
        step();
        ntotal++; if (val_a !== 1'b1) $display("FAIL zero_val: got %b want 1", val_a); else npass++;
        ntotal++; if ({i_a, q_a, i_b, q_b} !== 144'd0) $display("FAIL zero_out: got %0d/%0d/%0d/%0d want 0", i_a, q_a, i_b, q_b); else npass++;
        ntotal++; if (busy_a !== 1'b0) $display("FAIL zero_busy1: got %b want 0", busy_a); else npass++;
        step();
        ntotal++; if (val_a !== 1'b0) $display("FAIL zero_val_pulse: got %b want 0", val_a); else npass++;
        adc_val = 1'b0; ref_val = 1'b0;
    endtask

    task automatic test_max_n();
        int k;
        adc_data = 16'sd1; cos_ref = 16'sd1; sin_ref = -16'sd1;
        adc_val = 1'b1; ref_val = 1'b1;
        do_start(65535);
        wait_val(65600, k);
        adc_val = 1'b0; ref_val = 1'b0;
        ntotal++; if (k !== 65538) $display("FAIL maxn_latency: got %0d want 65538", k); else npass++;
        ntotal++; if (i_a !== 40'sd65535) $display("FAIL maxn_i: got %0d want 65535", i_a); else npass++;
        ntotal++; if (q_a !== -40'sd65535) $display("FAIL maxn_q: got %0d want -65535", q_a); else npass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_start_busy();
        test_abort();
        test_sat();
        test_zero();
        test_max_n();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
